// File: rtl/mult_seq.sv
// mult_seq -- sequential fixed-point lane multiplier.
//
// One transaction carries M signed lanes of x (activations) and w (weights),
// each N bits in Q(INTBITS).(FRACBITS). A single shared multiplier processes
// one lane per clock. Lane results are the full 2N-bit product shifted right
// arithmetically by FRACBITS and reduced back to N bits. The result vector is
// held until the downstream stage consumes it.
//
// Build option:
//   MULT_SAT_EN  defined   -> overflowing lanes saturate to the N-bit limits
//                undefined -> overflowing lanes keep their low N bits (wrap)
//   ovf is raised for any overflowing lane in either build.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   x_vec/w_vec carry a transaction
//   in_ready   block is idle and will accept a transaction
//   x_vec      activations, lane i at [N*(i+1)-1 : N*i]
//   w_vec      weights, same packing
//   out_valid  prod_vec/ovf hold a complete result
//   out_ready  downstream consumes the result
//   prod_vec   lane products, same packing
//   ovf        at least one lane overflowed in this transaction

module mult_seq #(
  parameter int M        = 8,
  parameter int N        = 32,
  parameter int INTBITS  = 12,
  parameter int FRACBITS = 20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*M-1:0] x_vec,
  input  logic [N*M-1:0] w_vec,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*M-1:0] prod_vec,
  output logic           ovf
);

  // A lane counter needs at least one bit even when M == 1.
  localparam int IDXW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

  // Binary point position; falls back to N-INTBITS if the two disagree.
  localparam int SHIFT = (INTBITS + FRACBITS == N) ? FRACBITS : (N - INTBITS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N*M-1:0]  x_q, x_d;
  logic [N*M-1:0]  w_q, w_d;
  logic [N*M-1:0]  prod_q, prod_d;
  logic            ovf_q, ovf_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  // Shared lane datapath
  logic signed [N-1:0]   x_lane;
  logic signed [N-1:0]   w_lane;
  logic signed [2*N-1:0] full_prod;
  logic signed [2*N-1:0] shifted;
  logic [N:0]            top_bits;
  logic                  lane_ovf;
  logic [N-1:0]          lane_res;

  always_comb begin
    x_lane    = x_q[int'(idx_q)*N +: N];
    w_lane    = w_q[int'(idx_q)*N +: N];
    full_prod = x_lane * w_lane;
    shifted   = full_prod >>> SHIFT;
    // The shifted value fits in N signed bits only if every bit from N-1
    // upward is a copy of the sign.
    top_bits  = shifted[2*N-1:N-1];
    lane_ovf  = !((&top_bits) || !(|top_bits));
`ifdef MULT_SAT_EN
    if (lane_ovf) begin
      lane_res = shifted[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      lane_res = shifted[N-1:0];
    end
`else
    lane_res = shifted[N-1:0];
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    w_d     = w_q;
    prod_d  = prod_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x_vec;
          w_d     = w_vec;
          prod_d  = '0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d[int'(idx_q)*N +: N] = lane_res;
        ovf_d                      = ovf_q | lane_ovf;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = HOLD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered copies of the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      w_q         <= '0;
      prod_q      <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      w_q         <= w_d;
      prod_q      <= prod_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign prod_vec  = prod_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

  localparam int M    = 8;
  localparam int N    = 32;
  localparam int INTB = 12;
  localparam int FRAC = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*M-1:0] x_vec;
  logic [N*M-1:0] w_vec;
  logic           out_valid;
  logic           out_ready;
  logic [N*M-1:0] prod_vec;
  logic           ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0]   tx_x [M];
  logic [N-1:0]   tx_w [M];
  logic [N*M-1:0] last_prod;
  logic           last_ovf;

  mult_seq #(.M(M), .N(N), .INTBITS(INTB), .FRACBITS(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_vec     (x_vec),
    .w_vec     (w_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_vec  (prod_vec),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, floor division by 2^FRAC, range test.
  function automatic void model_lane(input logic [N-1:0] x, input logic [N-1:0] w,
                                     output logic [N-1:0] r, output logic o);
    longint p;
    longint s;
    p = longint'($signed(x)) * longint'($signed(w));
    s = p >>> FRAC;
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef MULT_SAT_EN
    if (o) r = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else   r = 32'(s);
`else
    r = 32'(s);
`endif
  endfunction

  function automatic logic [N-1:0] rnd_operand();
    logic [N-1:0] v;
    int unsigned  mode;
    logic [N-1:0] edge_vals [6];
    edge_vals = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h0010_0000, 32'hFFF0_0000, 32'h0000_0001};
    mode = $urandom_range(0, 2);
    if (mode == 0)      v = $urandom;
    else if (mode == 1) v = {{8{1'b0}}, 24'($urandom)} ^ (($urandom & 1) != 0 ? 32'hFF00_0000 : 32'h0);
    else                v = edge_vals[$urandom_range(0, 5)];
    return v;
  endfunction

  // Drive one transaction, check latency/result, hold for `hold` cycles
  // (poking in_valid with junk), then consume.
  task automatic do_txn(input int hold, input string tag);
    logic [N*M-1:0] exp_vec;
    logic           exp_ovf;
    logic [N-1:0]   r;
    logic           o;
    int             lat;
    int             wait_cnt;
    exp_ovf = 1'b0;
    for (int i = 0; i < M; i++) begin
      model_lane(tx_x[i], tx_w[i], r, o);
      exp_vec[i*N +: N] = r;
      exp_ovf = exp_ovf | o;
      x_vec[i*N +: N] = tx_x[i];
      w_vec[i*N +: N] = tx_w[i];
    end
    in_valid = 1'b1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      @(posedge clk); #1; wait_cnt++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready: got %b want 1", tag, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_vec = {M{$urandom}};
    w_vec = {M{$urandom}};
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat != M) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, lat, M);
    end
    n_checks++;
    if (prod_vec !== exp_vec) begin
      n_fail++; $display("FAIL %s prod_vec: got %h want %h", tag, prod_vec, exp_vec);
    end
    n_checks++;
    if (ovf !== exp_ovf) begin
      n_fail++; $display("FAIL %s ovf: got %b want %b", tag, ovf, exp_ovf);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s in_ready_busy: got %b want 0", tag, in_ready);
    end
    last_prod = prod_vec;
    last_ovf  = ovf;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      x_vec = {M{$urandom}};
      w_vec = {M{$urandom}};
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || prod_vec !== exp_vec || ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL %s hold[%0d]: got v=%b r=%b ovf=%b p=%h want v=1 r=0 ovf=%b p=%h",
                 tag, k, out_valid, in_ready, ovf, prod_vec, exp_ovf, exp_vec);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s release: got v=%b r=%b want v=0 r=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_vec = '0; w_vec = '0;
    #12;
    n_checks++;
    if (prod_vec !== '0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got p=%h ovf=%b v=%b want all 0", prod_vec, ovf, out_valid);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic clear_tx();
    for (int i = 0; i < M; i++) begin tx_x[i] = '0; tx_w[i] = '0; end
  endtask

  task automatic test_directed();
    clear_tx();
    tx_x[0] = 32'h0020_0000; tx_w[0] = 32'h0030_0000;
    do_txn(5, "dir_lane0");
    n_checks++;
    if (last_prod !== {{(M-1)*N{1'b0}}, 32'h0060_0000} || last_ovf !== 1'b0) begin
      n_fail++; $display("FAIL dir_lane0_const: got %h ovf=%b want lane0=00600000 others 0 ovf=0", last_prod, last_ovf);
    end
    clear_tx();
    tx_x[3] = 32'hFFE8_0000; tx_w[3] = 32'h0020_0000;
    do_txn(0, "dir_lane3");
    n_checks++;
    if (last_prod[3*N +: N] !== 32'hFFD0_0000 || last_ovf !== 1'b0) begin
      n_fail++; $display("FAIL dir_lane3_const: got %h ovf=%b want FFD00000 ovf=0", last_prod[3*N +: N], last_ovf);
    end
    clear_tx();
    tx_x[5] = 32'h4000_0000; tx_w[5] = 32'h0040_0000;
    do_txn(1, "dir_lane5");
    n_checks++;
`ifdef MULT_SAT_EN
    if (last_prod[5*N +: N] !== 32'h7FFF_FFFF || last_ovf !== 1'b1) begin
      n_fail++; $display("FAIL dir_lane5_const: got %h ovf=%b want 7FFFFFFF ovf=1", last_prod[5*N +: N], last_ovf);
    end
`else
    if (last_prod[5*N +: N] !== 32'h0000_0000 || last_ovf !== 1'b1) begin
      n_fail++; $display("FAIL dir_lane5_const: got %h ovf=%b want 00000000 ovf=1", last_prod[5*N +: N], last_ovf);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    logic [N*M-1:0] ones_vec;
    for (int i = 0; i < M; i++) begin
      tx_x[i] = 32'h4000_0000; tx_w[i] = 32'h0040_0000;
      x_vec[i*N +: N] = tx_x[i]; w_vec[i*N +: N] = tx_w[i];
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (prod_vec !== '0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset: got p=%h ovf=%b v=%b want all 0", prod_vec, ovf, out_valid);
    end
    @(negedge clk); rst = 1'b0;
    repeat (M + 2) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL midrun_after: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
      end
    end
    for (int i = 0; i < M; i++) begin
      tx_x[i] = 32'h0010_0000; tx_w[i] = 32'h0010_0000;
      ones_vec[i*N +: N] = 32'h0010_0000;
    end
    do_txn(0, "midrun_next");
    n_checks++;
    if (last_prod !== ones_vec || last_ovf !== 1'b0) begin
      n_fail++; $display("FAIL midrun_next_const: got %h ovf=%b want %h ovf=0", last_prod, last_ovf, ones_vec);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < M; i++) begin
        tx_x[i] = rnd_operand();
        tx_w[i] = rnd_operand();
      end
      do_txn($urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < M; i++) begin
        tx_x[i] = rnd_operand();
        tx_w[i] = rnd_operand();
      end
      do_txn(0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter M, default 8: number of lanes (products per transaction).
REQ-002 SHALL have parameter N, default 32: lane width in bits, signed two's complement.
REQ-003 SHALL have parameter INTBITS, default 12: integer bits of the fixed-point format, including sign.
REQ-004 SHALL have parameter FRACBITS, default 20: fractional bits; INTBITS+FRACBITS == N.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  x_vec/w_vec carry a transaction.
REQ-008 SHALL have port in_ready  output  1  block accepts a transaction.
REQ-009 SHALL have port x_vec  input  N*M  activations; lane i at [N*(i+1)-1 : N*i].
REQ-010 SHALL have port w_vec  input  N*M  weights; same lane packing.
REQ-011 SHALL have port out_valid  output  1  prod_vec/ovf hold a complete result.
REQ-012 SHALL have port out_ready  input  1  downstream adder stage consumes the result.
REQ-013 SHALL have port prod_vec  output  N*M  lane products in Q(INTBITS).(FRACBITS); same packing; feeds the adder stage directly.
REQ-014 SHALL have port ovf  output  1  at least one lane overflowed in this transaction.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, HOLD with a lane counter idx of width clog2(M).
REQ-016 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in HOLD.
REQ-017 IDLE: on an edge with in_valid=1, SHALL latch x_vec/w_vec, clear prod_vec and ovf to 0, set idx=0, and enter RUN.
REQ-018 RUN: each edge SHALL compute lane idx with one shared multiplier, write it into prod_vec lane idx, and increment idx.
REQ-019 RUN: on the edge that writes lane M-1, SHALL enter HOLD; out_valid thus rises exactly M edges after acceptance.
REQ-020 Arithmetic: full 2N-bit signed product, arithmetic shift right by FRACBITS (truncation toward -inf), then reduced to N bits per REQ-029.
REQ-021 Lane overflow: the shifted product is outside [-2^(N-1), 2^(N-1)-1]; SHALL OR this into ovf (sticky within the transaction).
REQ-022 HOLD: prod_vec and ovf SHALL stay stable while out_ready=0 (indefinite backpressure).
REQ-023 HOLD: on an edge with out_ready=1, SHALL enter IDLE; a new transaction can be accepted no earlier than the following edge.
REQ-024 in_valid during RUN or HOLD SHALL be ignored, with no latch and no state change; upstream must hold it until in_ready.
REQ-025 Latched operands SHALL be unaffected by x_vec/w_vec changes after acceptance.
REQ-026 M=1 SHALL work: RUN lasts one edge.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, idx=0, prod_vec=0, ovf=0, out_valid=0, and in_ready=1 (after deassert).
REQ-028 rst mid-RUN or mid-HOLD SHALL abort the transaction; no partial result is ever flagged valid.

Configuration
REQ-029 Macro MULT_SAT_EN: if defined, an overflowing lane SHALL saturate to 2^(N-1)-1 (positive) or -2^(N-1) (negative); if undefined, it SHALL keep the low N bits (wrap). ovf behaviour is identical in both cases.

Verification
REQ-030 Lane0 x=0x00200000 (2.0), w=0x00300000 (3.0), other lanes 0 -> out_valid after 8 edges; lane0=0x00600000; others 0; ovf=0.
REQ-031 Lane3 x=0xFFE80000 (-1.5), w=0x00200000 (2.0) -> lane3=0xFFD00000; ovf=0.
REQ-032 Lane5 x=0x40000000 (1024.0), w=0x00400000 (4.0) -> ovf=1; lane5=0x7FFFFFFF with MULT_SAT_EN, 0x00000000 without.
REQ-033 out_ready=0 for 5 cycles after out_valid -> prod_vec stable; in_valid pulsed then is ignored; in_ready rises 1 cycle after out_ready=1.
REQ-034 rst asserted after lane 3 is written -> all outputs 0 at once; the next transaction (all lanes 1.0*1.0) gives every lane 0x00100000 with no stale data.
